// File: rtl/csa_pkg.sv
// Shared types and elaboration helpers for the chunked carry-propagate resolver.
package csa_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ADD,
        ST_DONE
    } state_t;

    function automatic int ceil_div(input int a, input int b);
        return (a + b - 1) / b;
    endfunction

    // Index width for n items, never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cpa_chunk.sv
// One CHUNK_W-bit slice of the carry-propagate adder, purely combinational.
module cpa_chunk #(
    parameter int CHUNK_W = 4
) (
    input  logic [CHUNK_W-1:0] a,
    input  logic [CHUNK_W-1:0] b,
    input  logic               cin,
    output logic [CHUNK_W-1:0] s,
    output logic               cout
);

    assign {cout, s} = {1'b0, a} + {1'b0, b} + (CHUNK_W+1)'(cin);

endmodule

// File: rtl/csa_cpa_resolver.sv
// Resolves a carry-save (sum, carry) pair into one binary result, CHUNK_W bits per cycle.
module csa_cpa_resolver
    import csa_pkg::*;
#(
    parameter int IN_W    = 9,
    parameter int CHUNK_W = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic [IN_W-1:0] i_sum,
    input  logic [IN_W-1:0] i_carry,
    output logic            o_valid,
    input  logic            i_ready,
    output logic [IN_W:0]   o_result,
    output logic            o_busy
);

    localparam int N_CHUNK = ceil_div(IN_W, CHUNK_W);
    localparam int EXT_W   = N_CHUNK * CHUNK_W;
    localparam int IDX_W   = idx_width(N_CHUNK);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CHUNK - 1);

    state_t             state;
    logic [IDX_W-1:0]   chunk_idx;
    logic               cin_q;
    logic [CHUNK_W-1:0] sum_c      [N_CHUNK];
    logic [CHUNK_W-1:0] carry_c    [N_CHUNK];
    logic [CHUNK_W-1:0] sum_in_c   [N_CHUNK];
    logic [CHUNK_W-1:0] carry_in_c [N_CHUNK];
    logic [EXT_W-1:0]   sum_ext;
    logic [EXT_W-1:0]   carry_ext;
    logic [CHUNK_W-1:0] chunk_s;
    logic               chunk_cout;
    logic [IN_W:0]      result_next;

    assign sum_ext   = EXT_W'(i_sum);
    assign carry_ext = EXT_W'(i_carry);

    for (genvar c = 0; c < N_CHUNK; c++) begin : g_split
        assign sum_in_c[c]   = sum_ext[c*CHUNK_W +: CHUNK_W];
        assign carry_in_c[c] = carry_ext[c*CHUNK_W +: CHUNK_W];
    end

    cpa_chunk #(.CHUNK_W(CHUNK_W)) u_chunk (
        .a    (sum_c[chunk_idx]),
        .b    (carry_c[chunk_idx]),
        .cin  (cin_q),
        .s    (chunk_s),
        .cout (chunk_cout)
    );

    // Each result bit is owned by exactly one chunk; it only changes on that chunk's cycle.
    for (genvar j = 0; j < IN_W; j++) begin : g_res
        localparam int CI = j / CHUNK_W;
        localparam int BI = j % CHUNK_W;
        assign result_next[j] = (chunk_idx == IDX_W'(CI)) ? chunk_s[BI] : o_result[j];
    end

    if (IN_W % CHUNK_W == 0) begin : g_top_cout
        assign result_next[IN_W] = (chunk_idx == LAST_IDX) ? chunk_cout : o_result[IN_W];
    end else begin : g_top_pad
        // Zero padding means bit IN_W is the only nonzero candidate; the higher pad bits
        // and the chunk carry-out are always zero, so folding them in leaves the value exact.
        localparam int BI = IN_W % CHUNK_W;
        assign result_next[IN_W] = (chunk_idx == LAST_IDX)
                                 ? (|chunk_s[CHUNK_W-1:BI]) | chunk_cout
                                 : o_result[IN_W];
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            chunk_idx <= '0;
            cin_q     <= 1'b0;
            o_result  <= '0;
            o_valid   <= 1'b0;
            o_busy    <= 1'b0;
            o_ready   <= 1'b1;
            // NOTE: the operand chunk arrays are tiny, so they are reset like any other flop.
            for (int c = 0; c < N_CHUNK; c++) begin
                sum_c[c]   <= '0;
                carry_c[c] <= '0;
            end
        end else begin
            case (state)
                ST_IDLE: begin
                    if (i_valid && o_ready) begin
                        sum_c     <= sum_in_c;
                        carry_c   <= carry_in_c;
                        chunk_idx <= '0;
                        cin_q     <= 1'b0;
                        o_ready   <= 1'b0;
                        o_busy    <= 1'b1;
                        state     <= ST_ADD;
                    end
                end
                ST_ADD: begin
                    o_result <= result_next;
                    cin_q    <= chunk_cout;
                    if (chunk_idx == LAST_IDX) begin
                        chunk_idx <= '0;
                        o_valid   <= 1'b1;
                        state     <= ST_DONE;
                    end else begin
                        chunk_idx <= chunk_idx + 1'b1;
                    end
                end
                ST_DONE: begin
                    if (i_ready) begin
                        o_valid <= 1'b0;
                        o_busy  <= 1'b0;
                        o_ready <= 1'b1;
                        state   <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_csa_cpa_resolver.sv
// Directed and swept checks of csa_cpa_resolver at CHUNK_W 4 (main) and 1/3/9 (sweep).
module tb_csa_cpa_resolver;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       i_valid;
    logic       i_ready;
    logic [8:0] i_sum;
    logic [8:0] i_carry;
    logic       o_ready;
    logic       o_valid;
    logic       o_busy;
    logic [9:0] o_result;

    logic       sw_valid   [3];
    logic [8:0] sw_sum     [3];
    logic [8:0] sw_carry   [3];
    logic       sw_o_ready [3];
    logic       sw_o_valid [3];
    logic       sw_o_busy  [3];
    logic [9:0] sw_result  [3];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    csa_cpa_resolver #(.IN_W(9), .CHUNK_W(4)) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_valid  (i_valid),
        .o_ready  (o_ready),
        .i_sum    (i_sum),
        .i_carry  (i_carry),
        .o_valid  (o_valid),
        .i_ready  (i_ready),
        .o_result (o_result),
        .o_busy   (o_busy)
    );

    for (genvar g = 0; g < 3; g++) begin : g_sw
        localparam int CW = (g == 0) ? 1 : ((g == 1) ? 3 : 9);
        csa_cpa_resolver #(.IN_W(9), .CHUNK_W(CW)) u_sw (
            .clk      (clk),
            .rst_n    (rst_n),
            .i_valid  (sw_valid[g]),
            .o_ready  (sw_o_ready[g]),
            .i_sum    (sw_sum[g]),
            .i_carry  (sw_carry[g]),
            .o_valid  (sw_o_valid[g]),
            .i_ready  (1'b1),
            .o_result (sw_result[g]),
            .o_busy   (sw_o_busy[g])
        );
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one pair on the main DUT, check latency and result, optionally complete the handshake.
    task automatic run_op(input logic [8:0] s, input logic [8:0] c, input logic [9:0] expv,
                          input string name, input bit hs);
        int t;
        t = 0;
        while (o_ready !== 1'b1 && t < 20) begin step(); t++; end
        n_checks++;
        if (o_ready !== 1'b1) begin
            n_fail++; $display("FAIL %s_ready_wait: o_ready=%b required 1", name, o_ready);
        end
        i_valid = 1'b1; i_sum = s; i_carry = c;
        step();
        i_valid = 1'b0;
        n_checks++;
        if (o_busy !== 1'b1 || o_ready !== 1'b0) begin
            n_fail++; $display("FAIL %s_accept: busy=%b ready=%b required 1/0", name, o_busy, o_ready);
        end
        t = 0;
        while (o_valid !== 1'b1 && t < 20) begin step(); t++; end
        n_checks++;
        if (t !== 3) begin
            n_fail++; $display("FAIL %s_latency: %0d cycles required 3", name, t);
        end
        n_checks++;
        if (o_result !== expv) begin
            n_fail++; $display("FAIL %s_result: got 0x%03h required 0x%03h", name, o_result, expv);
        end
        if (hs) begin
            step();
            n_checks++;
            if (o_valid !== 1'b0 || o_ready !== 1'b1) begin
                n_fail++; $display("FAIL %s_handshake: valid=%b ready=%b required 0/1", name, o_valid, o_ready);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; i_valid = 1'b0; i_ready = 1'b1; i_sum = '0; i_carry = '0;
        for (int g = 0; g < 3; g++) begin
            sw_valid[g] = 1'b0; sw_sum[g] = '0; sw_carry[g] = '0;
        end
        step(); step();
        n_checks++;
        if (o_valid !== 1'b0 || o_busy !== 1'b0 || o_result !== 10'h000) begin
            n_fail++; $display("FAIL reset_outputs: valid=%b busy=%b result=0x%03h required 0/0/0x000", o_valid, o_busy, o_result);
        end
        rst_n = 1'b1;
        step();
        n_checks++;
        if (o_ready !== 1'b1 || o_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_release: ready=%b valid=%b required 1/0", o_ready, o_valid);
        end
    endtask

    task automatic test_latency();
        i_ready = 1'b1;
        run_op(9'h0FF, 9'h001, 10'h100, "latency", 1'b1);
    endtask

    task automatic test_boundaries();
        run_op(9'h1FF, 9'h1FF, 10'h3FE, "all_ones", 1'b1);
        run_op(9'h000, 9'h000, 10'h000, "zeros", 1'b1);
        run_op(9'h1FF, 9'h001, 10'h200, "carry_out", 1'b1);
    endtask

    task automatic test_backpressure();
        i_ready = 1'b0;
        run_op(9'h123, 9'h045, 10'h168, "bp", 1'b0);
        for (int k = 0; k < 5; k++) begin
            step();
            n_checks++;
            if (o_valid !== 1'b1 || o_result !== 10'h168 || o_ready !== 1'b0) begin
                n_fail++; $display("FAIL bp_hold%0d: valid=%b result=0x%03h ready=%b required 1/0x168/0", k, o_valid, o_result, o_ready);
            end
        end
        i_ready = 1'b1;
        step();
        n_checks++;
        if (o_valid !== 1'b0 || o_ready !== 1'b1) begin
            n_fail++; $display("FAIL bp_release: valid=%b ready=%b required 0/1", o_valid, o_ready);
        end
    endtask

    task automatic test_ignore_busy();
        int t;
        i_ready = 1'b1;
        i_valid = 1'b1; i_sum = 9'h100; i_carry = 9'h023;
        step();
        i_sum = 9'h055; i_carry = 9'h0AA;
        t = 0;
        while (o_valid !== 1'b1 && t < 20) begin step(); t++; end
        n_checks++;
        if (o_result !== 10'h123) begin
            n_fail++; $display("FAIL ignore_first: got 0x%03h required 0x123", o_result);
        end
        step();
        step();
        i_valid = 1'b0;
        n_checks++;
        if (o_busy !== 1'b1) begin
            n_fail++; $display("FAIL ignore_second_accept: busy=%b required 1", o_busy);
        end
        t = 0;
        while (o_valid !== 1'b1 && t < 20) begin step(); t++; end
        n_checks++;
        if (o_result !== 10'h0FF) begin
            n_fail++; $display("FAIL ignore_second: got 0x%03h required 0x0FF", o_result);
        end
        step();
    endtask

    task automatic test_reset_mid();
        i_ready = 1'b1;
        i_valid = 1'b1; i_sum = 9'h0AB; i_carry = 9'h011;
        step();
        i_valid = 1'b0;
        step();
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (o_valid !== 1'b0 || o_busy !== 1'b0 || o_result !== 10'h000) begin
            n_fail++; $display("FAIL mid_reset: valid=%b busy=%b result=0x%03h required 0/0/0x000", o_valid, o_busy, o_result);
        end
        step();
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            n_checks++;
            if (o_valid !== 1'b0) begin
                n_fail++; $display("FAIL mid_reset_spurious%0d: valid=%b required 0", k, o_valid);
            end
        end
        run_op(9'h001, 9'h001, 10'h002, "post_reset", 1'b1);
    endtask

    task automatic test_sweep(input int g);
        int n_in, n_out, t;
        logic [8:0] a, b;
        logic [9:0] expv;
        n_in = 0; n_out = 0;
        for (int k = 0; k < 1000; k++) begin
            a = (k == 0) ? 9'h1FF : 9'($urandom_range(0, 511));
            b = (k == 0) ? 9'h1FF : 9'($urandom_range(0, 511));
            expv = {1'b0, a} + {1'b0, b};
            t = 0;
            while (sw_o_ready[g] !== 1'b1 && t < 30) begin step(); t++; end
            sw_valid[g] = 1'b1; sw_sum[g] = a; sw_carry[g] = b;
            step();
            sw_valid[g] = 1'b0;
            n_in++;
            n_checks++;
            if (sw_o_busy[g] !== 1'b1) begin
                n_fail++; $display("FAIL sweep%0d_busy%0d: busy=%b required 1", g, k, sw_o_busy[g]);
            end
            t = 0;
            while (sw_o_valid[g] !== 1'b1 && t < 30) begin step(); t++; end
            if (sw_o_valid[g] === 1'b1) n_out++;
            n_checks++;
            if (sw_result[g] !== expv || sw_o_valid[g] !== 1'b1) begin
                n_fail++; $display("FAIL sweep%0d_res%0d: 0x%03h+0x%03h got 0x%03h valid=%b required 0x%03h",
                                   g, k, a, b, sw_result[g], sw_o_valid[g], expv);
            end
            step();
        end
        n_checks++;
        if (n_in !== n_out) begin
            n_fail++; $display("FAIL sweep%0d_count: out=%0d required %0d", g, n_out, n_in);
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_boundaries();
        test_backpressure();
        test_ignore_busy();
        test_reset_mid();
        for (int g = 0; g < 3; g++) test_sweep(g);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
